// File: rtl/imem_responder.sv
// Purpose  : instruction-memory responder; serves word fetches from a RAM and returns inst+addr in order.
// Latency  : LATENCY cycles from request accept to rsp_valid (push into response FIFO at accept+LATENCY-1).
// Backpress: req_ready drops when in-flight + buffered reaches FIFO_DEPTH or during flush; rsp side holds under ~rsp_ready.
//
// Ports (imem_responder):
//   clk, reset              : clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready     : fetch request handshake, req_addr = byte address
//   rsp_valid/rsp_ready     : response handshake, rsp_addr/rsp_inst/rsp_err = payload
//   flush                   : discards every in-flight and buffered response
//   prog_we/prog_addr/data  : program-load write port (word granular, out-of-range dropped)
//   perf_req_cnt/stall_cnt  : accepted-request and stalled-cycle counters, only when IMEM_PERF_EN is defined
//
// Optional feature macro: IMEM_PERF_EN

// Purpose  : generic synchronous FIFO, registered first-word-fall-through output.
// Latency  : a push at edge N is visible on o_rd_vld/o_rd_dat in the cycle after edge N.
// Backpress: push is ignored when full unless a pop happens at the same edge; i_clr empties it.
module imem_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_wr_vld,
    input  logic [WIDTH-1:0] i_wr_dat,
    input  logic             i_rd_rdy,
    output logic             o_rd_vld,
    output logic [WIDTH-1:0] o_rd_dat
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_cnt;
    logic             w_pop;
    logic             w_push;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_rd_vld = (r_cnt != '0);
    assign o_rd_dat = r_mem[r_rd_ptr];
    assign w_pop    = o_rd_vld & i_rd_rdy;
    // When full, the write slot is the read slot; it is only safe to overwrite if it is being popped.
    assign w_push   = i_wr_vld & ((r_cnt != CW'(DEPTH)) | w_pop);

    // Storage is reset so the payload outputs read as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wr_dat;
                r_wr_ptr        <= nxt(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= nxt(r_rd_ptr);
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
        end
    end
endmodule

module imem_responder #(
    parameter int DEPTH      = 64,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_addr,
    output logic [31:0] rsp_inst,
    output logic        rsp_err,
    input  logic        flush,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_data
`ifdef IMEM_PERF_EN
    ,
    output logic [31:0] perf_req_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic        err;
        logic [31:0] addr;
        logic [31:0] inst;
    } rsp_t;

    typedef struct packed {
        logic vld;
        rsp_t rsp;
    } stage_t;

    logic [31:0]   r_mem [DEPTH];
    logic [CW-1:0] r_cnt;

    logic          w_accept;
    logic          w_pop;
    logic [AW-1:0] w_req_idx;
    logic          w_req_err;
    logic [AW-1:0] w_prog_idx;
    logic          w_prog_in_range;
    stage_t        w_s0;
    stage_t        w_push;
    rsp_t          w_rsp;

    // req_ready never looks at req_valid, so the fetch side can't form a combinational loop through us.
    assign req_ready = ~reset & ~flush & (r_cnt < CW'(FIFO_DEPTH));
    assign w_accept  = req_valid & req_ready;
    assign w_pop     = rsp_valid & rsp_ready;

    assign w_req_idx = req_addr[AW+1:2];
    assign w_req_err = (req_addr[1:0] != 2'b00) | (req_addr >= 32'(4 * DEPTH));

    // Byte-offset bits of prog_addr are don't-care; the shift folds them away.
    assign w_prog_idx      = prog_addr[AW+1:2];
    assign w_prog_in_range = (prog_addr >> 2) < 32'(DEPTH);

    always_ff @(posedge clk) begin
        if (prog_we && w_prog_in_range) r_mem[w_prog_idx] <= prog_data;
    end

    // RAM sampled at the accept edge: a same-edge program write is not yet visible, so old data is returned.
    always_comb begin
        w_s0          = '0;
        w_s0.vld      = w_accept;
        w_s0.rsp.err  = w_req_err;
        w_s0.rsp.addr = req_addr;
        w_s0.rsp.inst = w_req_err ? 32'h0 : r_mem[w_req_idx];
    end

    // LATENCY-1 register stages between the accept edge and the FIFO push edge.
    if (LATENCY == 1) begin : g_lat1
        assign w_push = w_s0;
    end else begin : g_pipe
        stage_t r_pipe [LATENCY-1];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < LATENCY - 1; i++) r_pipe[i] <= '0;
            end else if (flush) begin
                for (int i = 0; i < LATENCY - 1; i++) r_pipe[i] <= '0;
            end else begin
                r_pipe[0] <= w_s0;
                for (int i = 1; i < LATENCY - 1; i++) r_pipe[i] <= r_pipe[i-1];
            end
        end

        assign w_push = r_pipe[LATENCY-2];
    end

    imem_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst      (reset),
        .i_clr    (flush),
        .i_wr_vld (w_push.vld),
        .i_wr_dat (w_push.rsp),
        .i_rd_rdy (rsp_ready),
        .o_rd_vld (rsp_valid),
        .o_rd_dat (w_rsp)
    );

    assign rsp_err  = w_rsp.err;
    assign rsp_addr = w_rsp.addr;
    assign rsp_inst = w_rsp.inst;

    // Outstanding = pipeline + FIFO occupancy; bounding it by FIFO_DEPTH guarantees every push has a slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (w_accept && !w_pop) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (!w_accept && w_pop) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

`ifdef IMEM_PERF_EN
    logic [31:0] r_perf_req;
    logic [31:0] r_perf_stall;

    // Free-running, wrap naturally; flush deliberately leaves them alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_req   <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_accept)               r_perf_req   <= r_perf_req + 32'd1;
            if (req_valid && !req_ready) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_req_cnt   = r_perf_req;
    assign perf_stall_cnt = r_perf_stall;
`endif
endmodule

// File: tb/tb_imem_responder.sv
// Purpose  : directed self-checking bench for imem_responder (DEPTH=64, LATENCY=2, FIFO_DEPTH=4).
// Latency  : inputs driven and outputs sampled on the falling edge, half a cycle from the active edge.
// Backpress: exercises rsp_ready low, full buffer, flush and mid-stream reset.
module tb_imem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_addr;
    logic [31:0] rsp_inst;
    logic        rsp_err;
    logic        flush;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
`ifdef IMEM_PERF_EN
    logic [31:0] perf_req_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int acc;

    always #5 clk = ~clk;

    imem_responder #(
        .DEPTH      (64),
        .LATENCY    (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_addr  (rsp_addr),
        .rsp_inst  (rsp_inst),
        .rsp_err   (rsp_err),
        .flush     (flush),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data)
`ifdef IMEM_PERF_EN
        ,
        .perf_req_cnt   (perf_req_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic prog(input logic [31:0] a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    // One request, then the cycle in which its response becomes visible (LATENCY=2).
    task automatic single(input logic [31:0] a);
        req_valid = 1'b1; req_addr = a;
        tick();
        req_valid = 1'b0;
        tick();
    endtask

    task automatic burst(input int n, input logic [31:0] base, output int accepted);
        accepted = 0;
        for (int i = 0; i < n; i++) begin
            req_valid = 1'b1;
            req_addr  = base + 32'(4 * i);
            if (req_ready) accepted++;
            tick();
        end
        req_valid = 1'b0;
    endtask

    logic [31:0] exp_w [4];

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        flush = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        exp_w[0] = 32'hA0A0A0A0; exp_w[1] = 32'h00E60433;
        exp_w[2] = 32'h40860533; exp_w[3] = 32'h11111111;
        tick(); tick();

        check("rst_req_ready", {31'b0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_addr",  rsp_addr, 32'd0);
        check("rst_rsp_inst",  rsp_inst, 32'd0);
        check("rst_rsp_err",   {31'b0, rsp_err}, 32'd0);
        reset = 1'b0; #1;
        check("post_rst_ready", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < 4; i++) prog(32'(4 * i), exp_w[i]);
        prog(32'h0FC, 32'hCAFEF00D);
        prog(32'h017, 32'h55555555);  // byte offset ignored -> word 5
        prog(32'h104, 32'hBAD0BAD0);  // out of range, dropped

        // In-order back-to-back fetch
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h4;
        tick();
        req_addr = 32'h8;
        check("t1_not_early", {31'b0, rsp_valid}, 32'd0);
        tick();
        req_valid = 1'b0;
        check("t1_vld0",  {31'b0, rsp_valid}, 32'd1);
        check("t1_inst0", rsp_inst, 32'h00E60433);
        check("t1_addr0", rsp_addr, 32'h4);
        check("t1_err0",  {31'b0, rsp_err}, 32'd0);
        tick();
        check("t1_vld1",  {31'b0, rsp_valid}, 32'd1);
        check("t1_inst1", rsp_inst, 32'h40860533);
        check("t1_addr1", rsp_addr, 32'h8);
        tick();
        check("t1_drained", {31'b0, rsp_valid}, 32'd0);

        // Backpressure: buffer fills at FIFO_DEPTH outstanding
        rsp_ready = 1'b0;
        burst(6, 32'h0, acc);
        check("bp_accepted", 32'(acc), 32'd4);
        check("bp_ready_low", {31'b0, req_ready}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            check("bp_vld",  {31'b0, rsp_valid}, 32'd1);
            check("bp_addr", rsp_addr, 32'(4 * k));
            check("bp_inst", rsp_inst, exp_w[k]);
            rsp_ready = 1'b1;
            tick();
            if (k == 0) check("bp_ready_back", {31'b0, req_ready}, 32'd1);
        end
        check("bp_empty", {31'b0, rsp_valid}, 32'd0);

        // Errors and range boundaries
        single(32'h6);
        check("mis_err",  {31'b0, rsp_err}, 32'd1);
        check("mis_inst", rsp_inst, 32'd0);
        check("mis_addr", rsp_addr, 32'h6);
        tick();
        single(32'h100);
        check("oor_err",  {31'b0, rsp_err}, 32'd1);
        check("oor_inst", rsp_inst, 32'd0);
        tick();
        single(32'h0FC);
        check("last_err",  {31'b0, rsp_err}, 32'd0);
        check("last_inst", rsp_inst, 32'hCAFEF00D);
        tick();
        single(32'h14);
        check("prog_lowbits", rsp_inst, 32'h55555555);
        tick();
        single(32'h4);
        check("prog_oor_drop", rsp_inst, 32'h00E60433);
        tick();

        // Flush discards everything in flight
        rsp_ready = 1'b0;
        burst(3, 32'h0, acc);
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h8; #1;
        check("flush_ready", {31'b0, req_ready}, 32'd0);
        tick();
        flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("flush_no_rsp", {31'b0, rsp_valid}, 32'd0);
            tick();
        end
        single(32'h4);
        check("flush_after_vld",  {31'b0, rsp_valid}, 32'd1);
        check("flush_after_inst", rsp_inst, 32'h00E60433);
        tick();
        check("flush_after_one", {31'b0, rsp_valid}, 32'd0);
        rsp_ready = 1'b0;
        burst(5, 32'h0, acc);
        check("flush_cnt_zero", 32'(acc), 32'd4);
        rsp_ready = 1'b1;
        repeat (4) tick();
        check("flush_drain", {31'b0, rsp_valid}, 32'd0);

        // Program write racing a read of the same word
        prog_we = 1'b1; prog_addr = 32'hC; prog_data = 32'hDEADBEEF;
        req_valid = 1'b1; req_addr = 32'hC;
        tick();
        prog_we = 1'b0; req_valid = 1'b0;
        tick();
        check("raw_old", rsp_inst, 32'h11111111);
        tick();
        single(32'hC);
        check("raw_new", rsp_inst, 32'hDEADBEEF);
        tick();

        // Reset mid-stream
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h4;
        tick();
        req_addr = 32'h8;
        tick();
        req_valid = 1'b0;
        check("mid_pre_vld", {31'b0, rsp_valid}, 32'd1);
        reset = 1'b1; #1;
        check("mid_rst_vld",  {31'b0, rsp_valid}, 32'd0);
        check("mid_rst_rdy",  {31'b0, req_ready}, 32'd0);
        check("mid_rst_inst", rsp_inst, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("mid_pipe_clear", {31'b0, rsp_valid}, 32'd0);
        rsp_ready = 1'b1;
        single(32'h4);
        check("mid_ram_kept", rsp_inst, 32'h00E60433);
        tick();

`ifdef IMEM_PERF_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("perf_rst_req",   perf_req_cnt,   32'd0);
        check("perf_rst_stall", perf_stall_cnt, 32'd0);
        rsp_ready = 1'b0;
        burst(7, 32'h0, acc);
        rsp_ready = 1'b1;
        repeat (5) tick();
        single(32'h4);
        tick();
        check("perf_req",   perf_req_cnt,   32'd5);
        check("perf_stall", perf_stall_cnt, 32'd3);
        reset = 1'b1; #1;
        check("perf_clr_req",   perf_req_cnt,   32'd0);
        check("perf_clr_stall", perf_stall_cnt, 32'd0);
        check("perf_clr_vld",   {31'b0, rsp_valid}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
